// File: rtl/neuron_event_tx.sv
// neuron_event_tx: event-byte injector for the neuron core.
// Event bytes pushed locally are queued in a small circular FIFO. Each byte is
// then presented to the neuron over a 4-phase bundled-data req/ack handshake.
// The returning ack is asynchronous, so it passes through a synchronizer.
// A stalled phase is abandoned after TIMEOUT cycles, and the abort is recorded
// in a sticky error flag.
module neuron_event_tx #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_req,
  input  logic                     tx_ack,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL  = (AW+1)'(DEPTH);
  localparam logic [15:0] TIMEOUT_CYC = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    REL   = 2'd3
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [7:0]             mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            level;
  logic [15:0]            timer;
  logic [15:0]            timer_inc;
  logic                   push;
  logic                   pop;
  logic                   timeout_hit;
  logic                   timeout_fire;

  assign ack_s      = ack_sync[SYNC_STAGES-1];
  assign wr_ready   = (level != FULL_LEVEL);
  assign push       = wr_valid && wr_ready && ena;
  assign fifo_level = level;
  assign busy       = (state != IDLE) || (level != '0);

  // The timer counts the cycles spent in the current phase, including the
  // present one. This makes a phase last at most TIMEOUT enabled cycles.
  assign timer_inc   = (timer == 16'hFFFF) ? timer : timer + 16'd1;
  assign timeout_hit = (timer_inc >= TIMEOUT_CYC);

  // Ack synchronizer. It keeps sampling while disabled so the held ack stays
  // current when ena returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], tx_ack};
  end

  // FIFO storage. The contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves level as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Handshake sequencing. Nothing advances while ena is low. IDLE refuses to
  // start while a stale ack is still visible.
  always_comb begin
    next_state   = state;
    pop          = 1'b0;
    timeout_fire = 1'b0;
    if (ena) begin
      case (state)
        IDLE: begin
          if ((level != '0) && !ack_s) begin
            next_state = SETUP;
            pop        = 1'b1;
          end
        end
        SETUP: next_state = REQ;
        REQ: begin
          if (ack_s) begin
            next_state = REL;
          end else if (timeout_hit) begin
            next_state   = REL;
            timeout_fire = 1'b1;
          end
        end
        REL: begin
          if (!ack_s) begin
            next_state = IDLE;
          end else if (timeout_hit) begin
            next_state   = IDLE;
            timeout_fire = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State register. next_state already equals state while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Registered request line. It holds its level while disabled, which stalls
  // the handshake instead of aborting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   tx_req <= 1'b0;
    else if (ena) tx_req <= (next_state == REQ);
  end

  // Outgoing data is loaded only when a byte is popped. It stays stable for
  // the whole handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   tx_data <= 8'h00;
    else if (pop) tx_data <= mem[rd_ptr];
  end

  // Phase timer. It restarts on every state change and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (ena) begin
      if (next_state != state)               timer <= '0;
      else if ((state == REQ) || (state == REL)) timer <= timer_inc;
    end
  end

  // Sticky timeout flag. A clear wins over a set in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (ena) begin
      if (err_clr)           timeout_err <= 1'b0;
      else if (timeout_fire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/neuron_event_tx.md
# neuron_event_tx

Upstream event injector for the neuron core. It accepts 8-bit event bytes (spikes, ticks, config and special commands, already encoded) from a local push interface into a small FIFO. It then drives each byte into the neuron's input port with a 4-phase bundled-data req/ack handshake. The ack returning from the neuron is treated as asynchronous and synchronized internally, and a stalled handshake is caught by a timeout.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: flops in the ack synchronizer; ≥2.
- TIMEOUT, 255: cycles allowed in REQ or REL before abort; 1..65535.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; when low, all state holds. Synchronizer flops still sample.
- wr_valid  in  1  push request.
- wr_data  in  8  event byte to push.
- wr_ready  out  1  `!full`; a push is accepted when `wr_valid && wr_ready && ena`.
- tx_data  out  8  event byte presented to the neuron.
- tx_req  out  1  handshake request, registered.
- tx_ack  in  1  handshake acknowledge from the neuron; asynchronous.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- timeout_err  out  1  sticky; set on any handshake timeout.
- err_clr  in  1  clears timeout_err; has priority over a set in the same cycle.

## Operation
- FIFO:
  - Circular buffer with read/write pointers and a separate level counter.
  - Push and pop in the same cycle are both honoured, and level is unchanged.
  - Push when full is ignored because wr_ready=0.
  - Pop occurs only on IDLE→SETUP.
  - Pointers wrap modulo DEPTH.
- Ack synchronizer: SYNC_STAGES flops reset to 0; ack_s is the last stage.
- FSM states:
  - IDLE: tx_req=0. Moves to SETUP when FIFO is non-empty and ack_s=0. At that transition the head is loaded into tx_data and popped.
  - SETUP: tx_data stable, tx_req=0. Lasts 1 cycle, then REQ. This provides data setup before req rises.
  - REQ: tx_req=1. When ack_s=1, moves to REL. If the timer reaches TIMEOUT first, sets timeout_err and moves to REL with tx_req=0; that byte is dropped and not retried.
  - REL: tx_req=0. When ack_s=0, moves to IDLE. On timeout, sets timeout_err and forces IDLE.
- tx_data holds its value from SETUP until the next SETUP; it never changes while tx_req=1 or ack_s=1.
- Timer:
  - 16-bit, cleared on entry to REQ and REL, incremented each enabled cycle in those states.
  - Saturates; compared with `>= TIMEOUT`.
- ena=0: FSM, FIFO, timer and error flag all freeze. tx_req holds its current level, so the handshake is stalled, not aborted.

## Timing
- Reset values: tx_req=0, tx_data=0, wr_ready=1, fifo_level=0, busy=0, timeout_err=0; FSM in IDLE; synchronizer=0.
- Latency from push to request, for an empty FIFO in IDLE with push accepted in cycle N:
  - FIFO non-empty in N+1.
  - SETUP in N+2.
  - tx_req=1 in N+3.
- ack path: tx_ack rising is seen as ack_s after SYNC_STAGES edges. tx_req falls on the edge after that.
- Minimum handshake for an immediate ack, with SYNC_STAGES=2: SETUP(1) + REQ(≥3) + REL(≥3). That is ≥7 cycles per byte.
- Back-to-back bytes: the next SETUP starts the cycle after REL→IDLE. There are no bubbles beyond the IDLE cycle.
- A new request is never raised while ack_s=1. This guards a late ack after a REL timeout.
- Reset mid-handshake: tx_req drops asynchronously, and the FIFO contents and in-flight byte are lost.
- Simultaneous push into a full FIFO with a pop on IDLE→SETUP: the push is rejected, because wr_ready reflects the registered full state.

## Test plan
- Reset then idle: after reset, tx_req=0, wr_ready=1, fifo_level=0, busy=0, timeout_err=0.
- Single event, with a responder that acks 2 cycles after req and releases 2 cycles after req falls:
  - Push 0x85 at cycle N.
  - tx_data=0x85 from N+2, tx_req rises at N+3.
  - Exactly one handshake occurs, then busy=0.
- Fill and order:
  - Push 0x01..0x08 with ack held low; fifo_level reaches 7 (one byte is in flight) and the 9th push is accepted. The FIFO then fills: level=DEPTH and wr_ready=0, and the next push is ignored.
  - Release ack; the responder receives bytes in order with no loss or duplication.
- Simultaneous push/pop at level=3 during IDLE→SETUP: level stays at 3.
- Timeout:
  - Set TIMEOUT=10 with the responder never acking. tx_req falls 10 cycles after rising and timeout_err=1. The next byte's SETUP follows.
  - err_clr pulse gives timeout_err=0 next cycle.
- ena gating and reset:
  - Deassert ena for 20 cycles mid-REQ: tx_req stays 1, and the timer and level are unchanged. The handshake resumes when ena returns.
  - Assert rst_n low mid-REQ: tx_req drops immediately and level=0.
